// File: rtl/mcs51_intc.sv
// MCS-51 style interrupt controller: 5 sources, fixed in-level order, optional
// two-level priority with nesting (define MCS51_INTC_PRIO_EN), reti holdoff.
module mcs51_intc #(
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  src_flag,
  input  logic [1:0]  it_mode,
  input  logic [7:0]  ie,
  input  logic [7:0]  ip,
  input  logic        int_ack,
  input  logic        reti_pulse,
  output logic        int_req,
  output logic [15:0] int_vector,
  output logic        int_prio,
  output logic [2:0]  int_src,
  output logic [4:0]  int_clr,
  output logic [1:0]  in_service
);

  localparam logic [1:0] HOLD_LOAD = 2'(HOLDOFF_CYCLES);

  logic [1:0]  hold_cnt;
  logic [1:0]  hold_nxt;
  logic [1:0]  svc_nxt;
  logic [4:0]  elig;
  logic [4:0]  hi_mask;
  logic [4:0]  lo_mask;
  logic        ack_ok;
  logic        win_ok;
  logic        win_prio;
  logic [2:0]  win_src;
  logic        req_nxt;
  logic [4:0]  clr_nxt;

  // Lowest index wins within a level: INT0 > T0 > INT1 > T1 > SER.
  function automatic logic [2:0] pick_first(input logic [4:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign elig = {5{ie[7]}} & ie[4:0] & src_flag;

`ifdef MCS51_INTC_PRIO_EN
  assign hi_mask = elig & ip[4:0];
  logic ie_unused;
  assign ie_unused = ^{ie[6:5], ip[7:5]};
`else
  assign hi_mask = 5'b0;
  logic ip_unused;
  assign ip_unused = ^{ie[6:5], ip};
`endif

  assign lo_mask = elig & ~hi_mask;
  assign ack_ok  = int_ack & int_req;

  always_comb begin
    svc_nxt  = in_service;
    hold_nxt = 2'd0;
    win_ok   = 1'b0;
    win_prio = 1'b0;
    win_src  = 3'd0;
    clr_nxt  = 5'b0;

    // RETI releases the most recent level before a same-cycle ack is recorded.
    if (reti_pulse) begin
      if (svc_nxt[1]) svc_nxt[1] = 1'b0;
      else            svc_nxt[0] = 1'b0;
    end
    if (ack_ok) svc_nxt[int_prio] = 1'b1;

    if (reti_pulse)          hold_nxt = HOLD_LOAD;
    else if (hold_cnt != 0)  hold_nxt = hold_cnt - 2'd1;

    if (|hi_mask) begin
      win_src  = pick_first(hi_mask);
      win_prio = 1'b1;
      win_ok   = ~svc_nxt[1];
    end else if (|lo_mask) begin
      win_src  = pick_first(lo_mask);
      win_prio = 1'b0;
      win_ok   = (svc_nxt == 2'b00);
    end

    // Hardware clears edge-latched and timer flags; level INTx and serial stay.
    if (ack_ok) begin
      case (int_src)
        3'd0:    clr_nxt[0] = it_mode[0];
        3'd1:    clr_nxt[1] = 1'b1;
        3'd2:    clr_nxt[2] = it_mode[1];
        3'd3:    clr_nxt[3] = 1'b1;
        default: clr_nxt    = 5'b0;
      endcase
    end
  end

  assign req_nxt = win_ok & ~ack_ok & (hold_nxt == 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_req    <= 1'b0;
      int_vector <= 16'h0000;
      int_prio   <= 1'b0;
      int_src    <= 3'd0;
      int_clr    <= 5'b0;
      in_service <= 2'b00;
      hold_cnt   <= 2'd0;
    end else begin
      int_req    <= req_nxt;
      int_clr    <= clr_nxt;
      in_service <= svc_nxt;
      hold_cnt   <= hold_nxt;
      if (req_nxt) begin
        int_vector <= {10'b0, win_src, 3'b011};
        int_prio   <= win_prio;
        int_src    <= win_src;
      end
    end
  end

endmodule

// File: tb/tb_mcs51_intc.sv
// Randomized bench for mcs51_intc against a service-stack reference model.
module tb_mcs51_intc;

  localparam int H = 2;
`ifdef MCS51_INTC_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  src_flag;
  logic [1:0]  it_mode;
  logic [7:0]  ie;
  logic [7:0]  ip;
  logic        int_ack;
  logic        reti_pulse;
  logic        int_req;
  logic [15:0] int_vector;
  logic        int_prio;
  logic [2:0]  int_src;
  logic [4:0]  int_clr;
  logic [1:0]  in_service;

  always #5 clk = ~clk;

  mcs51_intc #(.HOLDOFF_CYCLES(H)) dut (
    .clk(clk), .reset_n(reset_n), .src_flag(src_flag), .it_mode(it_mode),
    .ie(ie), .ip(ip), .int_ack(int_ack), .reti_pulse(reti_pulse),
    .int_req(int_req), .int_vector(int_vector), .int_prio(int_prio),
    .int_src(int_src), .int_clr(int_clr), .in_service(in_service)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: active service levels kept as a stack (newest at back).
  bit         m_req;
  int         m_vec, m_prio, m_src;
  logic [4:0] m_clr;
  int         stk[$];
  int         since;

  function automatic logic [1:0] m_svc();
    logic [1:0] s;
    s = 2'b00;
    foreach (stk[k]) s[stk[k]] = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    m_req = 0; m_vec = 0; m_prio = 0; m_src = 0; m_clr = '0;
    stk.delete();
    since = 100;
  endtask

  task automatic model_step();
    bit accepted;
    int best, best_lvl, lvl;
    bit allowed;
    logic [1:0] s;
    accepted = int_ack && m_req;
    m_clr = '0;
    if (accepted) begin
      if (m_src == 1 || m_src == 3) m_clr[m_src] = 1'b1;
      if (m_src == 0) m_clr[0] = it_mode[0];
      if (m_src == 2) m_clr[2] = it_mode[1];
    end
    if (reti_pulse && stk.size() > 0) void'(stk.pop_back());
    if (accepted) stk.push_back(m_prio);
    if (reti_pulse) since = 0;
    else if (since < 100) since++;
    best = -1; best_lvl = 0;
    for (int i = 0; i < 5; i++) begin
      if (ie[7] && ie[i] && src_flag[i]) begin
        lvl = (PRIO && ip[i]) ? 1 : 0;
        if (best < 0 || lvl > best_lvl) begin
          best = i; best_lvl = lvl;
        end
      end
    end
    s = m_svc();
    allowed = (best_lvl == 1) ? !s[1] : (s == 2'b00);
    m_req = (best >= 0) && allowed && !accepted && (since >= H);
    if (m_req) begin
      m_vec = 3 + 8 * best; m_prio = best_lvl; m_src = best;
    end
  endtask

  task automatic compare_all();
    check("int_req", int_req, m_req);
    check("int_clr", int_clr, m_clr);
    check("in_service", in_service, m_svc());
    if (m_req) begin
      check("int_vector", int_vector, m_vec);
      check("int_src", int_src, m_src);
      check("int_prio", int_prio, m_prio);
    end
  endtask

  task automatic cyc(input logic [4:0] f, input logic [1:0] itm, input logic [7:0] e,
                     input logic [7:0] p, input logic a, input logic r);
    @(negedge clk);
    compare_all();
    src_flag = f; it_mode = itm; ie = e; ip = p; int_ack = a; reti_pulse = r;
    model_step();
  endtask

  task automatic check_reset_zero();
    check("rst_int_req", int_req, 0);
    check("rst_int_vector", int_vector, 0);
    check("rst_int_prio", int_prio, 0);
    check("rst_int_src", int_src, 0);
    check("rst_int_clr", int_clr, 0);
    check("rst_in_service", in_service, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare_all();
    reset_n = 1'b0;
    #1;
    check_reset_zero();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    src_flag = '0; it_mode = '0; ie = '0; ip = '0; int_ack = 0; reti_pulse = 0;
    model_step();
  endtask

  initial begin
    reset_n = 1'b0;
    src_flag = '0; it_mode = '0; ie = '0; ip = '0; int_ack = 0; reti_pulse = 0;
    model_reset();
    #1;
    check_reset_zero();
    @(negedge clk);
    reset_n = 1'b1;
    model_step();

    // Single INT0 request, then all flags with T1 high priority, ack, reti.
    cyc(5'b00001, 2'b00, 8'h81, 8'h00, 0, 0);
    cyc(5'b00001, 2'b00, 8'h81, 8'h00, 0, 0);
    cyc(5'b11111, 2'b00, 8'h9F, 8'h08, 0, 0);
    cyc(5'b11111, 2'b00, 8'h9F, 8'h08, 1, 0);
    cyc(5'b11111, 2'b00, 8'h9F, 8'h08, 0, 0);
    cyc(5'b11111, 2'b00, 8'h9F, 8'h08, 0, 0);
    cyc(5'b11111, 2'b00, 8'h9F, 8'h08, 0, 1);
    for (int i = 0; i < 5; i++) cyc(5'b11111, 2'b00, 8'h9F, 8'h08, 0, 0);
    // Low T0 in service, then high INT0 nests over it.
    cyc(5'b00010, 2'b00, 8'h83, 8'h01, 1, 0);
    cyc(5'b00010, 2'b00, 8'h83, 8'h01, 1, 0);
    cyc(5'b00001, 2'b00, 8'h83, 8'h01, 0, 0);
    cyc(5'b00001, 2'b00, 8'h83, 8'h01, 1, 0);
    cyc(5'b00001, 2'b00, 8'h83, 8'h01, 0, 1);
    cyc(5'b00000, 2'b00, 8'h83, 8'h01, 0, 0);
    cyc(5'b00000, 2'b00, 8'h83, 8'h01, 0, 1);
    for (int i = 0; i < 4; i++) cyc(5'b10000, 2'b00, 8'h90, 8'hFF, i == 1, 0);

    do_reset();

    for (int n = 0; n < 4000; n++) begin
      logic [7:0] e;
      e = 8'($urandom);
      e[7] = ($urandom_range(0, 9) != 0);
      cyc(5'($urandom) & 5'($urandom | $urandom), 2'($urandom), e, 8'($urandom),
          $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
      if (n % 900 == 450) do_reset();
    end

    @(negedge clk);
    compare_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcs51_intc.md
MCS51_INTC -- requirements
Module: mcs51_intc

Interface
REQ-001 Parameter: HOLDOFF_CYCLES, 1, number of cycles int_req is forced low after a reti_pulse (range 0-3).
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 src_flag  input  5  raw flags: [0]=IE0, [1]=TF0, [2]=IE1, [3]=TF1, [4]=RI|TI.
REQ-005 it_mode  input  2  TCON IT0/IT1; 1 marks the external source edge-triggered.
REQ-006 ie  input  8  IE SFR: EA=bit7, ES=4, ET1=3, EX1=2, ET0=1, EX0=0.
REQ-007 ip  input  8  IP SFR: PS=4, PT1=3, PX1=2, PT0=1, PX0=0.
REQ-008 int_ack  input  1  one-cycle pulse; core accepts the presented vector.
REQ-009 reti_pulse  input  1  one-cycle pulse; core executed RETI.
REQ-010 int_req  output  1  registered interrupt request to core.
REQ-011 int_vector  output  16  registered vector of presented source.
REQ-012 int_prio  output  1  registered level of presented source (1=high).
REQ-013 int_src  output  3  registered index 0-4 of presented source.
REQ-014 int_clr  output  5  one-cycle flag-clear strobes to the timer/serial SFR block.
REQ-015 in_service  output  2  [1]=high level active, [0]=low level active.

Function
REQ-016 Eligible source i SHALL require ie[7], its enable bit, and src_flag[i] all 1.
REQ-017 Fixed order within a level SHALL be INT0 > T0 > INT1 > T1 > SER; every eligible high source SHALL beat every eligible low source.
REQ-018 Vectors SHALL be 0x0003, 0x000B, 0x0013, 0x001B, 0x0023 for sources 0-4.
REQ-019 Winner SHALL be presented when: high winner and in_service[1]=0; low winner and in_service=00.
REQ-020 int_req/int_vector/int_prio/int_src SHALL be re-registered every cycle from the current winner: one-cycle latency from flag to int_req; when no winner, int_req=0 and the other three SHALL hold their last values.
REQ-021 A flag deasserting before ack SHALL drop or retarget int_req on the next cycle.
REQ-022 int_ack while int_req=1 SHALL set the in_service bit of int_prio on the next edge and force int_req=0 for that next cycle.
REQ-023 int_ack while int_req=0 SHALL be ignored.
REQ-024 On an accepted ack, int_clr SHALL pulse for one cycle: bit1/bit3 always; bit0/bit2 only if it_mode[0]/it_mode[1]=1; bit4 never.
REQ-025 reti_pulse SHALL clear in_service[1] if set, else in_service[0]; with in_service=00 it SHALL have no effect.
REQ-026 After reti_pulse, int_req SHALL be 0 for HOLDOFF_CYCLES cycles following the pulse; a holdoff counter SHALL track this, and a new reti_pulse SHALL restart it.
REQ-027 Simultaneous reti_pulse and int_ack SHALL apply the reti clear first, then the ack set.
REQ-028 A high source arriving with in_service=01 SHALL be presented (nesting); nothing SHALL be presented with in_service[1]=1.
REQ-029 ie[7]=0 SHALL suppress int_req without altering in_service.

Reset
REQ-030 reset_n low SHALL immediately clear int_req, int_vector, int_prio, int_src, int_clr, in_service, and the holdoff counter to 0.
REQ-031 Reset mid-service SHALL discard nesting state; after release, the first request SHALL be presented 1 cycle after a qualifying flag.

Configuration
REQ-032 With MCS51_INTC_PRIO_EN defined, two-level priority and nesting per REQ-017/REQ-028 SHALL apply.
REQ-033 Without MCS51_INTC_PRIO_EN, ip SHALL be ignored: all sources are low, int_prio=0, in_service[1] stays 0, and no nesting occurs.

Verification
REQ-034 ie=0x81, src_flag=00001 -> next cycle int_req=1, int_vector=0x0003, int_src=0, int_prio=0.
REQ-035 ie=0x9F, ip=0x08, src_flag=11111 -> int_src=3, int_vector=0x001B, int_prio=1; ack -> in_service=10, int_clr=01000 for one cycle, int_req=0 the following cycle.
REQ-036 in_service=01 (T0 low), ip=0x01, INT0 flag set -> int_req=1, vector 0x0003, int_prio=1; ack -> in_service=11; reti -> 01; reti -> 00.
REQ-037 it_mode=00, INT0 acked -> int_clr[0] stays 0; serial acked -> int_clr=00000 and int_req reasserts after service ends while RI remains 1.
REQ-038 HOLDOFF_CYCLES=2, pending T1 during reti_pulse -> int_req=0 for 2 cycles, then 1; simultaneous reti+ack -> in_service reflects clear then set.
REQ-039 Build without MCS51_INTC_PRIO_EN, ip=0xFF, low service active, INT0 flag -> int_req stays 0 until reti.
